// File: rtl/fb_ctrl_pkg.sv
// Shared types and constants for the framebuffer sequencer.
// Four pixels are packed per 32-bit SRAM word.
package fb_ctrl_pkg;

  typedef enum logic [1:0] {
    FB_IDLE = 2'd0,
    FB_LOAD = 2'd1,
    FB_FULL = 2'd2,
    FB_DUMP = 2'd3
  } fb_state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_SEL_W     = 2;

endpackage

// File: rtl/fb_byte_packer.sv
// Packs a pixel stream into words, little-endian by arrival order.
// done_o fires combinationally on the 4th push with the complete word.
module fb_byte_packer
  import fb_ctrl_pkg::*;
#(
  parameter int PIX_W = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clr_i,
  input  logic                        push_i,
  input  logic [PIX_W-1:0]            pix_i,
  output logic                        done_o,
  output logic [BYTES_PER_WORD*PIX_W-1:0] word_o
);

  localparam int HOLD_W = (BYTES_PER_WORD-1)*PIX_W;

  logic [BYTE_SEL_W-1:0] cnt_q;
  logic [HOLD_W-1:0]     hold_q;

  // Oldest pixel drifts to the low byte as newer ones shift in on top.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      hold_q <= '0;
    end else if (clr_i) begin
      cnt_q  <= '0;
      hold_q <= '0;
    end else if (push_i) begin
      cnt_q  <= cnt_q + 1'b1;
      hold_q <= {pix_i, hold_q[HOLD_W-1:PIX_W]};
    end
  end

  assign done_o = push_i && !clr_i &&
    (cnt_q == BYTE_SEL_W'(BYTES_PER_WORD-1));
  assign word_o = {pix_i, hold_q};

endmodule

// File: rtl/fb_seq_ctrl.sv
// Framebuffer sequencer: packs pixels into SRAM words (LOAD)
// and streams them back out with valid/ready flow control (DUMP).
module fb_seq_ctrl
  import fb_ctrl_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter int PIX_W  = 8,
  localparam int DATA_W = BYTES_PER_WORD*PIX_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic              dump_start,
  input  logic              abort,
  input  logic              s_valid,
  input  logic [PIX_W-1:0]  s_data,
  output logic              s_ready,
  output logic              m_valid,
  output logic [PIX_W-1:0]  m_data,
  input  logic              m_ready,
  output logic              sram_wr_en,
  output logic [ADDR_W-1:0] sram_wr_addr,
  output logic [DATA_W-1:0] sram_wr_data,
  output logic              sram_rd_en,
  output logic [ADDR_W-1:0] sram_rd_addr,
  input  logic [DATA_W-1:0] sram_rd_data,
  output logic [1:0]        state,
  output logic              load_done,
  output logic              dump_done
);

  fb_state_e             state_q;
  logic                  s_ready_q, m_valid_q;
  logic                  wr_en_q, rd_en_q;
  logic                  load_done_q, dump_done_q;
  logic [ADDR_W-1:0]     wr_word_q, wr_addr_q, rd_addr_q;
  logic [DATA_W-1:0]     wr_data_q, pk_word;
  logic [BYTE_SEL_W-1:0] sel_q;

  logic idle_or_full, start_load, start_dump;
  logic push, pk_done, pk_clr;
  logic m_hs, last_byte, last_word, refetch;

  assign idle_or_full = (state_q == FB_IDLE) ||
                        (state_q == FB_FULL);
  assign start_load = load_start && idle_or_full && !abort;
  assign start_dump = dump_start && !load_start && !abort &&
                      (state_q == FB_FULL);

  assign push = s_valid && s_ready_q && !abort &&
                (state_q == FB_LOAD);
  assign pk_clr = abort || start_load;

  fb_byte_packer #(.PIX_W(PIX_W)) u_packer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (pk_clr),
    .push_i (push),
    .pix_i  (s_data),
    .done_o (pk_done),
    .word_o (pk_word)
  );

  assign m_hs = m_valid_q && m_ready && !abort &&
                (state_q == FB_DUMP);
  assign last_byte = sel_q == BYTE_SEL_W'(BYTES_PER_WORD-1);
  assign last_word = rd_addr_q == '1;
  // Fetch the next word in the same cycle byte 3 leaves: no bubble.
  assign refetch = m_hs && last_byte && !last_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FB_IDLE;
      s_ready_q   <= 1'b0;
      m_valid_q   <= 1'b0;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      load_done_q <= 1'b0;
      dump_done_q <= 1'b0;
      wr_word_q   <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      rd_addr_q   <= '0;
      sel_q       <= '0;
    end else begin
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      load_done_q <= 1'b0;
      dump_done_q <= 1'b0;
      if (abort) begin
        state_q   <= FB_IDLE;
        s_ready_q <= 1'b0;
        m_valid_q <= 1'b0;
      end else if (start_load) begin
        state_q   <= FB_LOAD;
        s_ready_q <= 1'b1;
        wr_word_q <= '0;
      end else if (start_dump) begin
        state_q   <= FB_DUMP;
        rd_en_q   <= 1'b1;
        rd_addr_q <= '0;
        sel_q     <= '0;
      end else begin
        unique case (state_q)
          FB_LOAD: begin
            if (pk_done) begin
              wr_en_q   <= 1'b1;
              wr_addr_q <= wr_word_q;
              wr_data_q <= pk_word;
              wr_word_q <= wr_word_q + 1'b1;
              if (wr_word_q == '1) begin
                state_q     <= FB_FULL;
                load_done_q <= 1'b1;
                s_ready_q   <= 1'b0;
              end
            end
          end
          FB_DUMP: begin
            if (rd_en_q) m_valid_q <= 1'b1;
            if (m_hs) begin
              sel_q <= sel_q + 1'b1;
              if (refetch) begin
                rd_addr_q <= rd_addr_q + 1'b1;
              end else if (last_byte) begin
                m_valid_q   <= 1'b0;
                dump_done_q <= 1'b1;
                state_q     <= FB_FULL;
              end
            end
          end
          FB_IDLE, FB_FULL: ;
        endcase
      end
    end
  end

  assign s_ready      = s_ready_q;
  assign m_valid      = m_valid_q;
  assign m_data       = m_valid_q ?
    sram_rd_data[PIX_W*sel_q +: PIX_W] : '0;
  assign sram_wr_en   = wr_en_q;
  assign sram_wr_addr = wr_addr_q;
  assign sram_wr_data = wr_data_q;
  assign sram_rd_en   = rd_en_q || refetch;
  assign sram_rd_addr = refetch ? rd_addr_q + 1'b1 : rd_addr_q;
  assign state        = state_q;
  assign load_done    = load_done_q;
  assign dump_done    = dump_done_q;

endmodule
